// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: execute->memory boundary, valid/ready with 2-entry skid.
// Optional stall counter port when EX_MEM_PERF_CNT_EN is defined.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             drop all held entries
//   in_*              execute-side handshake and payload
//   out_*             memory-side handshake and held entry
//   out_misaligned    misalignment flag captured with the entry
//   fwd_*             forwarding tap for the hazard unit
//   stall_cycles      (EX_MEM_PERF_CNT_EN) out_valid && !out_ready count
module ex_mem_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic                  in_alu_zero,
  input  logic [XLEN-1:0]       in_store_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [2:0]            in_funct3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_alu_result,
  output logic                  out_alu_zero,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic [2:0]            out_funct3,
  output logic                  out_misaligned,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_value
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  typedef struct packed {
    logic [XLEN-1:0]       alu_result;
    logic                  alu_zero;
    logic [XLEN-1:0]       store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            funct3;
    logic                  misaligned;
  } ent_t;

  ent_t r_main;
  ent_t r_skid;
  logic r_main_valid;
  logic r_skid_valid;

  ent_t w_in;
  logic w_mis;
  logic w_accept;
  logic w_drain;

  always_comb begin
    w_mis = 1'b0;
    unique case (in_funct3[1:0])
      2'b01:   w_mis = in_alu_result[0];
      2'b10:   w_mis = |in_alu_result[1:0];
      default: w_mis = 1'b0;
    endcase
    // Non-memory ops never trap on alignment.
    if (!(in_mem_read || in_mem_write))
      w_mis = 1'b0;
  end

  always_comb begin
    w_in            = '0;
    w_in.alu_result = in_alu_result;
    w_in.alu_zero   = in_alu_zero;
    w_in.store_data = in_store_data;
    w_in.rd         = in_rd;
    w_in.reg_write  = in_reg_write;
    w_in.mem_read   = in_mem_read;
    w_in.mem_write  = in_mem_write;
    w_in.funct3     = in_funct3;
    w_in.misaligned = w_mis;
  end

  // Ready depends only on held state and flush, never on out_ready.
  assign in_ready = !r_skid_valid && !flush;
  assign w_accept = in_valid && in_ready;
  assign out_valid = r_main_valid;
  assign w_drain = r_main_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (!r_main_valid || w_drain) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main       <= w_in;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= 1'b0;
        end
      end
      // Main is held this cycle, so the new entry parks in the skid.
      if (w_accept && r_main_valid && !w_drain) begin
        r_skid       <= w_in;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign out_alu_result = r_main.alu_result;
  assign out_alu_zero   = r_main.alu_zero;
  assign out_store_data = r_main.store_data;
  assign out_rd         = r_main.rd;
  assign out_reg_write  = r_main.reg_write;
  assign out_mem_read   = r_main.mem_read;
  assign out_mem_write  = r_main.mem_write;
  assign out_funct3     = r_main.funct3;
  assign out_misaligned = r_main.misaligned;

  assign fwd_valid = r_main_valid && r_main.reg_write
                   && (r_main.rd != '0);
  assign fwd_rd    = r_main.rd;
  assign fwd_value = r_main.alu_result;

`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk) begin
    if (rst)
      r_stall <= '0;
    else if (r_main_valid && !out_ready)
      r_stall <= r_stall + 32'd1;
  end
  assign stall_cycles = r_stall;
`endif

  a_skid_implies_main: assert property (
    @(posedge clk) disable iff (rst)
    r_skid_valid |-> r_main_valid
  );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: scoreboard bench for ex_mem_pipe.
// Directed handshake, misalign, flush, forwarding and reset checks.
module tb_ex_mem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic        in_alu_zero;
  logic [31:0] in_store_data;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_mem_read;
  logic        in_mem_write;
  logic [2:0]  in_funct3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_result;
  logic        out_alu_zero;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic [2:0]  out_funct3;
  logic        out_misaligned;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_value;
`ifdef EX_MEM_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  ex_mem_pipe #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero),
    .in_store_data(in_store_data), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_funct3(in_funct3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_result(out_alu_result), .out_alu_zero(out_alu_zero),
    .out_store_data(out_store_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_funct3(out_funct3),
    .out_misaligned(out_misaligned),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_value(fwd_value)
`ifdef EX_MEM_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic [15:0] ctl;
  } exp_t;

  exp_t sb[$];

  function automatic logic mis_model(input logic [2:0] f3,
                                     input logic [31:0] a,
                                     input logic mr,
                                     input logic mw);
    if (!mr && !mw) return 1'b0;
    if (f3[1:0] == 2'b01) return a[0] != 1'b0;
    if (f3[1:0] == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Monitor: pop on drain, clear on flush/reset, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", {out_alu_result, out_store_data}, e.data);
          chk("sb_ctl", 64'({out_alu_zero, out_rd, out_reg_write,
                             out_mem_read, out_mem_write,
                             out_funct3, out_misaligned}),
              64'(e.ctl));
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = {in_alu_result, in_store_data};
        e.ctl  = 16'({in_alu_zero, in_rd, in_reg_write,
                      in_mem_read, in_mem_write, in_funct3,
                      mis_model(in_funct3, in_alu_result,
                                in_mem_read, in_mem_write)});
        sb.push_back(e);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic rw, input logic mr,
                       input logic mw);
    in_valid      = v;
    in_alu_result = a;
    in_alu_zero   = (a == 32'd0);
    in_store_data = ~a;
    in_rd         = rd;
    in_reg_write  = rw;
    in_mem_read   = mr;
    in_mem_write  = mw;
    in_funct3     = f3;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    idle();
    do_reset();

    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("rst_mis", 64'(out_misaligned), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming at full rate, one cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1'b1, 32'h10 + 32'(4 * i), 3'b010, 5'd3,
            1'b1, 1'b1, 1'b0);
      @(negedge clk);
      chk("strm_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) begin
        chk("strm_valid", 64'(out_valid), 64'd1);
        chk("strm_res", 64'(out_alu_result),
            64'(32'h10 + 32'(4 * (i - 1))));
      end
    end
    step();
    idle();
    @(negedge clk);
    chk("strm_last_valid", 64'(out_valid), 64'd1);
    chk("strm_last_res", 64'(out_alu_result), 64'h1C);
    step();
    @(negedge clk);
    chk("strm_empty", 64'(out_valid), 64'd0);

    // Backpressure: fill main and skid, then drain in order.
    out_ready = 1'b0;
    step();
    drive(1'b1, 32'h10, 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_rdy0", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 32'h14, 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_rdy1", 64'(in_ready), 64'd1);
    step();
    drive(1'b1, 32'h18, 3'b010, 5'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp_rdy2", 64'(in_ready), 64'd0);
    chk("bp_hold", 64'(out_alu_result), 64'h10);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_d0_res", 64'(out_alu_result), 64'h10);
    chk("bp_d0_rdy", 64'(in_ready), 64'd0);
    step();
    @(negedge clk);
    chk("bp_d1_res", 64'(out_alu_result), 64'h14);
    chk("bp_d1_rdy", 64'(in_ready), 64'd1);
    step();
    idle();
    @(negedge clk);
    chk("bp_d2_res", 64'(out_alu_result), 64'h18);
    chk("bp_d2_valid", 64'(out_valid), 64'd1);
    step();

    // Misalignment flag captured with the entry.
    begin
      logic [2:0]  f3s [5] = '{3'b010, 3'b001, 3'b010, 3'b101, 3'b000};
      logic [31:0] ads [5] = '{32'h1002, 32'h1002, 32'h1002,
                               32'h1003, 32'h1003};
      logic        mrs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      logic        mws [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        exs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
        drive(1'b1, ads[i], f3s[i], 5'd2, 1'b0, mrs[i], mws[i]);
        step();
        idle();
        @(negedge clk);
        chk($sformatf("mis_%0d", i), 64'(out_misaligned),
            64'(exs[i]));
        step();
      end
    end

    // Flush with main and skid full, input offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 3'b010, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h44, 3'b010, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hBAD0, 3'b010, 5'd4, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_rdy", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy_after", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("fl_stays_empty", 64'(out_valid), 64'd0);

    // Forwarding tap.
    step();
    drive(1'b1, 32'h55, 3'b000, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hDEADBEEF, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("fwd_rd0_valid", 64'(out_valid), 64'd1);
    chk("fwd_rd0", 64'(fwd_valid), 64'd0);
    step();
    drive(1'b1, 32'h77, 3'b000, 5'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fwd_v", 64'(fwd_valid), 64'd1);
    chk("fwd_rd", 64'(fwd_rd), 64'd5);
    chk("fwd_val", 64'(fwd_value), 64'hDEADBEEF);
    step();
    idle();
    @(negedge clk);
    chk("fwd_nowr", 64'(fwd_valid), 64'd0);
    step();

    // Reset mid-operation discards held entries.
    out_ready = 1'b0;
    drive(1'b1, 32'h80, 3'b010, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h84, 3'b010, 5'd6, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_rdy", 64'(in_ready), 64'd1);
    chk("mrst_res", 64'(out_alu_result), 64'd0);

`ifdef EX_MEM_PERF_CNT_EN
    step();
    drive(1'b1, 32'h90, 3'b010, 5'd7, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("perf_7", 64'(stall_cycles), 64'd7);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("perf_rst", 64'(stall_cycles), 64'd0);
`endif

    step();
    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
